// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and constants for the RSA exponentiation core.
package rsa_pkg;

  localparam int RSA_W  = 256;
  localparam int RSA_CW = 9;

  localparam logic [RSA_W-1:0] RSA_ONE = {{(RSA_W-1){1'b0}}, 1'b1};

  // Sequencer states of rsa_exp_ctrl.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_LOAD,
    ST_PRE_WAIT,
    ST_LOOP,
    ST_MUL,
    ST_MUL_WAIT,
    ST_SQR_CHK,
    ST_SQR,
    ST_SQR_WAIT,
    ST_NEXT,
    ST_DONE
  } rsa_ctrl_state_t;

endpackage

// File: rtl/rsa_exp_iter.sv
// rsa_exp_iter: iteration counter plus LSB-first exponent shifter.
// Reports the current exponent bit, whether all higher bits are zero,
// whether this is the final iteration, and whether the loop has run out.
module rsa_exp_iter
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int CW = RSA_CW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] e_in,
  output logic         bit0,
  output logic         rest_zero,
  output logic         last,
  output logic         expired
);

  logic [W-1:0]  r_e;
  logic [CW-1:0] r_i;

  // Load a fresh exponent with i=0, or consume one bit per NEXT step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
      r_i <= '0;
    end else if (load) begin
      r_e <= e_in;
      r_i <= '0;
    end else if (shift) begin
      r_e <= r_e >> 1;
      r_i <= r_i + CW'(1);
    end
  end

  assign bit0      = r_e[0];
  assign rest_zero = (r_e[W-1:1] == '0);
  assign last      = (r_i == CW'(W - 1));
  assign expired   = (r_i == CW'(W));

endmodule

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: sequencer for RSA exponentiation. Runs pre-processing to get
// T = Y*2^W mod N, then an LSB-first square-and-multiply loop on one shared
// Montgomery multiplier, returning Y^E mod N.
// Build option: define RSA_CTRL_EARLY_EXIT_EN to end the loop once the
// remaining exponent bits are zero (not constant-time). Default build always
// runs W iterations.
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int CW = RSA_CW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] e_in,
  input  logic [W-1:0] n_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         pp_beg,
  output logic [W-1:0] pp_m,
  output logic [W-1:0] pp_n,
  input  logic         pp_ready,
  input  logic [W-1:0] pp_out,
  output logic         mont_start,
  output logic [W-1:0] mont_a,
  output logic [W-1:0] mont_b,
  output logic [W-1:0] mont_n,
  input  logic         mont_done,
  input  logic [W-1:0] mont_out
);

`ifdef RSA_CTRL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  rsa_ctrl_state_t r_state, w_state_nxt;

  logic [W-1:0] r_y, r_n, r_t, r_m, r_result;
  logic         r_busy, r_done;

  logic w_accept, w_bit0, w_rest_zero, w_last, w_expired;
  logic w_exit, w_skip_sqr;

  // Only IDLE and DONE have busy low, so a start elsewhere has no effect.
  assign w_accept   = start & ~r_busy;
  assign w_exit     = w_expired | (EARLY_EXIT & ~w_bit0 & w_rest_zero);
  assign w_skip_sqr = w_last | (EARLY_EXIT & w_rest_zero);

  rsa_exp_iter #(
    .W  (W),
    .CW (CW)
  ) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (w_accept),
    .shift     (r_state == ST_NEXT),
    .e_in      (e_in),
    .bit0      (w_bit0),
    .rest_zero (w_rest_zero),
    .last      (w_last),
    .expired   (w_expired)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps this purely combinational; a path
  // that left w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE,
      ST_DONE:     w_state_nxt = w_accept ? ST_PRE_LOAD : ST_IDLE;
      ST_PRE_LOAD: w_state_nxt = ST_PRE_WAIT;
      ST_PRE_WAIT: if (pp_ready) w_state_nxt = ST_LOOP;
      ST_LOOP: begin
        if (w_exit)      w_state_nxt = ST_DONE;
        else if (w_bit0) w_state_nxt = ST_MUL;
        else             w_state_nxt = ST_SQR_CHK;
      end
      ST_MUL:      w_state_nxt = ST_MUL_WAIT;
      ST_MUL_WAIT: if (mont_done) w_state_nxt = ST_SQR_CHK;
      ST_SQR_CHK:  w_state_nxt = w_skip_sqr ? ST_NEXT : ST_SQR;
      ST_SQR:      w_state_nxt = ST_SQR_WAIT;
      ST_SQR_WAIT: if (mont_done) w_state_nxt = ST_NEXT;
      ST_NEXT:     w_state_nxt = ST_LOOP;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and Montgomery operand select, decoded from the current state.
  always_comb begin
    pp_beg     = 1'b1;
    mont_start = 1'b0;
    mont_a     = r_t;
    case (r_state)
      ST_PRE_LOAD: pp_beg = 1'b0;
      ST_MUL: begin
        mont_start = 1'b1;
        mont_a     = r_m;
      end
      ST_MUL_WAIT: mont_a = r_m;
      ST_SQR:      mont_start = 1'b1;
      default:     ;
    endcase
  end

  // Operand latch, captures on unit pulses in their WAIT states, and the
  // result/done/busy update on the loop exit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y      <= '0;
      r_n      <= '0;
      r_t      <= '0;
      r_m      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_y    <= y_in;
        r_n    <= n_in;
        r_m    <= W'(RSA_ONE);
        r_busy <= 1'b1;
      end
      if (r_state == ST_PRE_WAIT && pp_ready)  r_t <= pp_out;
      if (r_state == ST_MUL_WAIT && mont_done) r_m <= mont_out;
      if (r_state == ST_SQR_WAIT && mont_done) r_t <= mont_out;
      if (r_state == ST_LOOP && w_exit) begin
        r_result <= r_m;
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign pp_m   = r_y;
  assign pp_n   = r_n;
  assign mont_b = r_t;
  assign mont_n = r_n;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: bench for rsa_exp_ctrl with behavioural pre-processing
// (latency 3) and Montgomery (latency 5) units, a per-cycle monitor checked
// against a plain modular-exponentiation model, and directed jobs.
module tb_rsa_exp_ctrl;

  localparam int W          = 256;
  localparam int PP_LAT     = 3;
  localparam int MONT_LAT   = 5;
  localparam int JOB_BUDGET = 6000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] y_in, e_in, n_in;
  logic         busy, done;
  logic [W-1:0] result;
  logic         pp_beg;
  logic [W-1:0] pp_m, pp_n;
  logic         pp_ready;
  logic [W-1:0] pp_out;
  logic         mont_start;
  logic [W-1:0] mont_a, mont_b, mont_n;
  logic         mont_done;
  logic [W-1:0] mont_out;

  int n_tests;
  int n_fail;
  int n_mont_starts;
  int extra_delay;

  rsa_exp_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .y_in       (y_in),
    .e_in       (e_in),
    .n_in       (n_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .pp_beg     (pp_beg),
    .pp_m       (pp_m),
    .pp_n       (pp_n),
    .pp_ready   (pp_ready),
    .pp_out     (pp_out),
    .mont_start (mont_start),
    .mont_a     (mont_a),
    .mont_b     (mont_b),
    .mont_n     (mont_n),
    .mont_done  (mont_done),
    .mont_out   (mont_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Y * 2^W mod N
  function automatic logic [W-1:0] pp_ref(input logic [W-1:0] y, input logic [W-1:0] n);
    logic [2*W-1:0] x;
    x = {y, {W{1'b0}}};
    x = x % {{W{1'b0}}, n};
    return x[W-1:0];
  endfunction

  // a * b * 2^-W mod N, bit-serial reduction (a, b < N, N odd)
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
    logic [W+1:0] t;
    t = '0;
    for (int k = 0; k < W; k++) begin
      if (a[k]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, n};
      t = t >> 1;
    end
    if (t >= {2'b00, n}) t = t - {2'b00, n};
    return t[W-1:0];
  endfunction

  // Y^E mod N by ordinary modular arithmetic
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] y, input logic [W-1:0] e,
                                               input logic [W-1:0] n);
    logic [2*W-1:0] r, b, nn;
    nn = {{W{1'b0}}, n};
    r  = (2*W)'(1) % nn;
    b  = {{W{1'b0}}, y} % nn;
    for (int k = 0; k < W; k++) begin
      if (e[k]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[W-1:0];
  endfunction

  // Number of Montgomery products the job must launch
  function automatic int exp_products(input logic [W-1:0] e);
`ifdef RSA_CTRL_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int k = 0; k < W; k++) if (e[k]) msb = k;
    if (msb < 0) return 0;
    return $countones(e) + msb;
`else
    return $countones(e) + W - 1;
`endif
  endfunction

  // Pre-processing unit model
  initial begin : pp_model
    logic [W-1:0] pm, pn;
    bit abort;
    pp_ready = 1'b0;
    pp_out   = '0;
    forever begin
      @(negedge clk);
      pp_ready = 1'b0;
      if (!reset && !pp_beg) begin
        pm    = pp_m;
        pn    = pp_n;
        abort = 1'b0;
        repeat (PP_LAT) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
        end
        if (!abort) begin
          pp_out   = pp_ref(pm, pn);
          pp_ready = 1'b1;
        end
      end
    end
  end

  // Montgomery unit model; checks operands stay put while a product runs
  initial begin : mont_model
    logic [W-1:0] ca, cb, cn;
    int lat;
    bit abort;
    mont_done = 1'b0;
    mont_out  = '0;
    forever begin
      @(negedge clk);
      mont_done = 1'b0;
      if (!reset && mont_start) begin
        n_mont_starts++;
        ca          = mont_a;
        cb          = mont_b;
        cn          = mont_n;
        lat         = MONT_LAT + extra_delay;
        extra_delay = 0;
        abort       = 1'b0;
        repeat (lat) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
          if (!abort) begin
            check_vec("mont_a_stable", mont_a, ca);
            check_vec("mont_b_stable", mont_b, cb);
            check_vec("mont_n_stable", mont_n, cn);
            check_bit("mont_no_reissue", mont_start, 1'b0);
          end
        end
        if (!abort) begin
          mont_out  = mont_ref(ca, cb, cn);
          mont_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle monitor against the job-level model
  initial begin : monitor
    bit pending, armed;
    int cyc, mcnt, ppl, jcnt, acnt;
    logic [W-1:0] jy, jn, jexp, ay, an, aexp, hold;
    pending = 1'b0;
    armed   = 1'b0;
    hold    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 1'b0;
        armed   = 1'b0;
        hold    = '0;
      end else begin
        if (armed) begin
          pending = 1'b1;
          armed   = 1'b0;
          cyc = 0; mcnt = 0; ppl = 0;
          jy = ay; jn = an; jexp = aexp; jcnt = acnt;
        end
        if (pending) begin
          cyc++;
          if (mont_start) mcnt++;
          if (!pp_beg) ppl++;
          check_bit("pp_beg_window", pp_beg, cyc != 1);
          check_vec("pp_m_latched", pp_m, jy);
          check_vec("pp_n_latched", pp_n, jn);
          check_vec("mont_n_latched", mont_n, jn);
          if (done) begin
            check_bit("busy_at_done", busy, 1'b0);
            check_vec("result_model", result, jexp);
            check_int("product_count", mcnt, jcnt);
            check_int("pp_beg_once", ppl, 1);
            hold    = jexp;
            pending = 1'b0;
          end else begin
            check_bit("busy_in_job", busy, 1'b1);
          end
        end else begin
          check_bit("idle_busy", busy, 1'b0);
          check_bit("idle_done", done, 1'b0);
          check_vec("idle_result_hold", result, hold);
          check_bit("idle_pp_beg", pp_beg, 1'b1);
          check_bit("idle_mont_start", mont_start, 1'b0);
        end
        if (!pending && start && !busy) begin
          armed = 1'b1;
          ay    = y_in;
          an    = n_in;
          aexp  = ref_modexp(y_in, e_in, n_in);
          acnt  = exp_products(e_in);
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] y, input logic [W-1:0] e, input logic [W-1:0] n);
    @(posedge clk);
    #1;
    y_in  = y;
    e_in  = e;
    n_in  = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [W-1:0] exp, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < JOB_BUDGET) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    check_bit({name, "_done_seen"}, seen, 1'b1);
    check_vec({name, "_result"}, result, exp);
  endtask

  initial begin : main
    logic [W-1:0] big_n;
    int c_basic, c_tmp, base, k;

    n_tests = 0; n_fail = 0; n_mont_starts = 0; extra_delay = 0;
    reset = 1'b1; start = 1'b0;
    y_in = '0; e_in = '0; n_in = '0;
    big_n = {1'b1, 255'd95};

    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_vec("rst_result", result, '0);
    check_bit("rst_pp_beg", pp_beg, 1'b1);
    check_bit("rst_mont_start", mont_start, 1'b0);

    // Hand-computed values pinning the models (2^256 = 3 mod 13, 3^-1 = 9 mod 13)
    check_vec("pin_pp", pp_ref(W'(2), W'(13)), W'(6));
    check_vec("pin_mont_sqr", mont_ref(W'(6), W'(6), W'(13)), W'(12));
    check_vec("pin_mont_mul", mont_ref(W'(1), W'(6), W'(13)), W'(2));
    check_vec("pin_modexp_a", ref_modexp(W'(2), W'(5), W'(13)), W'(6));
    check_vec("pin_modexp_b", ref_modexp(W'(3), W'(7), W'(13)), W'(3));
    check_vec("pin_modexp_e0", ref_modexp(W'(4), W'(0), W'(13)), W'(1));
`ifdef RSA_CTRL_EARLY_EXIT_EN
    check_int("pin_count_e5", exp_products(W'(5)), 4);
    check_int("pin_count_e0", exp_products(W'(0)), 0);
`else
    check_int("pin_count_e5", exp_products(W'(5)), 257);
    check_int("pin_count_e0", exp_products(W'(0)), 255);
`endif

    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic job
    launch(W'(2), W'(5), W'(13));
    wait_done("job_basic", W'(6), c_basic);

    // Zero exponent
    launch(W'(4), W'(0), W'(13));
    wait_done("job_e_zero", W'(1), c_tmp);

    // Wide modulus, Y = N-1, E = 3
    launch(big_n - W'(1), W'(3), big_n);
    wait_done("job_big", big_n - W'(1), c_tmp);

    // Second start while busy is ignored
    launch(W'(3), W'(7), W'(13));
    repeat (8) @(posedge clk);
    launch(W'(2), W'(5), W'(11));
    wait_done("job_restart", W'(3), c_tmp);

    // Reset while a square is outstanding (second product of E=5)
    base = n_mont_starts;
    launch(W'(2), W'(5), W'(13));
    k = 0;
    while (n_mont_starts < base + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_int("rst_reach_sqr", n_mont_starts, base + 2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_bit("midrst_busy", busy, 1'b0);
    check_vec("midrst_result", result, '0);
    check_bit("midrst_done", done, 1'b0);
    check_bit("midrst_pp_beg", pp_beg, 1'b1);
    check_bit("midrst_mont_start", mont_start, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    launch(W'(2), W'(5), W'(13));
    wait_done("job_post_reset", W'(6), c_tmp);
    check_int("post_reset_cycles", c_tmp, c_basic);

    // First product held 200 extra cycles in MUL_WAIT
    extra_delay = 200;
    launch(W'(2), W'(5), W'(13));
    wait_done("job_delay", W'(6), c_tmp);
    check_int("delay_cycles", c_tmp, c_basic + 200);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
